multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MEM_WAIT_EN, default 1; when 0, memready is ignored and treated as constant 1.
REQ-002 Port: clk  in  1  single clock; all state changes on the rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: op  in  6  instruction opcode from the instruction register.
REQ-005 Port: funct  in  6  R-type function field.
REQ-006 Port: zero  in  1  ALU zero flag.
REQ-007 Port: memready  in  1  memory access completes this cycle.
REQ-008 Port: memwrite, irwrite, regwrite, regdst, memtoreg, iord, alusrca  out  1 each  datapath controls.
REQ-009 Port: alusrcb  out  2  00 rd2, 01 const 4, 10 signimm, 11 signimm<<2.
REQ-010 Port: pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 Port: alucontrol  out  3  ALU operation from the ALU decoder.
REQ-012 Port: pcen  out  1  PC write enable.
REQ-013 Port: state  out  4  current FSM state, for debug.

Function
REQ-014 States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 are illegal.
REQ-015 Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
REQ-016 FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite and pcwrite assert only when memready=1; state holds until memready=1, then goes to DECODE.
REQ-017 DECODE: alusrca=0, alusrcb=11, aluop=00; next state is lw/sw->MEMADR, R->EXECUTE, beq->BRANCH, addi->ADDIEX, j->JUMP; any other opcode->FETCH (executes as a NOP).
REQ-018 MEMADR: alusrca=1, alusrcb=10, aluop=00; next state is MEMRD for lw, MEMWR for sw.
REQ-019 MEMRD: iord=1; state holds until memready=1, then goes to MEMWB.
REQ-020 MEMWB: regdst=0, memtoreg=1, regwrite=1; next state FETCH.
REQ-021 MEMWR: iord=1, memwrite=1; memwrite stays high while waiting; next state is FETCH when memready=1.
REQ-022 EXECUTE: alusrca=1, alusrcb=00, aluop=10; next state ALUWB. ALUWB: regdst=1, memtoreg=0, regwrite=1; next state FETCH.
REQ-023 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1; next state FETCH.
REQ-024 ADDIEX: alusrca=1, alusrcb=10, aluop=00; next state ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1; next state FETCH.
REQ-025 JUMP: pcsrc=10, pcwrite=1; next state FETCH.
REQ-026 Any output not listed for a state is 0.
REQ-027 pcen = pcwrite | (branch & zero), combinational.
REQ-028 alucontrol decoding: aluop 00 -> 010, 01 -> 110, 10 -> funct-decoded (add 010, sub 110, and 000, or 001, slt 111, others xxx).
REQ-029 All outputs except pcen, irwrite and pcwrite are Moore outputs, decoded from state only.
REQ-030 An illegal state code goes to FETCH on the next edge, with all write enables 0 while in it.
REQ-031 Instruction latency with memready tied 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-032 A rising edge with reset=1 sets state=FETCH, overriding any wait or transition in progress.
REQ-033 While reset=1, memwrite, irwrite, regwrite, pcen and pcwrite are forced to 0.
REQ-034 The first FETCH after reset deasserts begins on the first edge with reset=0.

Structure
REQ-035 State encodings, opcode constants, alusrcb/pcsrc encodings and aluop codes live in a shared package/header.
REQ-036 The existing ALU decoder is instantiated as the single sub-module (aludec) to produce alucontrol; the state register and next-state/output logic are local.

Verification
REQ-037 Reset held 3 cycles mid-MEMRD, then released -> state=0; irwrite, pcwrite and pcen are 1 in the first cycle after release (memready=1).
REQ-038 lw (op 100011), memready=1 -> states 0,1,2,3,4; regwrite=1 only in state 4, with memtoreg=1.
REQ-039 sw, memready low for 2 extra cycles in MEMWR -> memwrite=1 for 3 consecutive cycles, then state 0.
REQ-040 beq with zero=1 -> pcen=1 in BRANCH with pcsrc=01; beq with zero=0 -> pcen=0.
REQ-041 R-type funct 101010 -> alucontrol=111 in EXECUTE; opcode 111111 -> DECODE then FETCH, no write enables asserted.
REQ-042 MEM_WAIT_EN=0 with memready=0 -> FETCH advances to DECODE after 1 cycle.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings and state output decode for the multicycle controller
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [1:0] SRCB_RD2    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Moore control word; jump is the state-only part of pcwrite
   typedef struct packed {
      logic       memwrite;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       iord;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
      logic       branch;
      logic       jump;
   } ctrl_t;

   // Control word for a state; illegal codes decode to all zeros
   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:   c.alusrcb = SRCB_FOUR;
         S_DECODE:  c.alusrcb = SRCB_IMMSH2;
         S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; end
         S_MEMRD:   c.iord = 1'b1;
         S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
         S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
         S_EXECUTE: begin c.alusrca = 1'b1; c.alusrcb = SRCB_RD2; c.aluop = ALUOP_FUNCT; end
         S_ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
         S_BRANCH:  begin
            c.alusrca = 1'b1;
            c.aluop   = ALUOP_SUB;
            c.pcsrc   = PCSRC_ALUOUT;
            c.branch  = 1'b1;
         end
         S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; end
         S_ADDIWB:  c.regwrite = 1'b1;
         S_JUMP:    begin c.pcsrc = PCSRC_JUMP; c.jump = 1'b1; end
         default:   c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_aludec.sv
// rtl/multicycle_ctrl_aludec.sv - ALU operation decoder from aluop and funct
module multicycle_ctrl_aludec
   import multicycle_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   input  logic [1:0] aluop,
   output logic [2:0] alucontrol
);

   // Fixed add/sub for address and branch compare, funct field otherwise
   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         default: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: alucontrol = 3'bxxx;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle processor main control FSM
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       memready,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       iord,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       pcen,
   output logic [3:0] state
);

   state_t state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;
   logic   mem_ok;
   logic   pcwrite;

   // Without wait support the memory is treated as always ready
   assign mem_ok = MEM_WAIT_EN ? memready : 1'b1;

   // Next-state logic; the control word is decoded from the next state so
   // the registered outputs always match the state they belong to
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:   if (mem_ok) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   if (mem_ok) state_d = S_MEMWB;
         S_MEMWR:   if (mem_ok) state_d = S_FETCH;
         S_EXECUTE: state_d = S_ALUWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
         default:   state_d = S_FETCH;
      endcase
      ctrl_d = decode_ctrl(state_d);
   end

   // State and Moore control register; reset wins over any wait
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         ctrl_q  <= decode_ctrl(S_FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Memory-handshake dependent enables, all held off during reset
   always_comb begin
      irwrite  = ~reset & (state_q == S_FETCH) & mem_ok;
      pcwrite  = ~reset & (((state_q == S_FETCH) & mem_ok) | ctrl_q.jump);
      pcen     = pcwrite | (~reset & ctrl_q.branch & zero);
      memwrite = ~reset & ctrl_q.memwrite;
      regwrite = ~reset & ctrl_q.regwrite;
   end

   assign regdst   = ctrl_q.regdst;
   assign memtoreg = ctrl_q.memtoreg;
   assign iord     = ctrl_q.iord;
   assign alusrca  = ctrl_q.alusrca;
   assign alusrcb  = ctrl_q.alusrcb;
   assign pcsrc    = ctrl_q.pcsrc;
   assign state    = state_q;

   multicycle_ctrl_aludec aludec (
      .funct      (funct),
      .aluop      (ctrl_q.aluop),
      .alucontrol (alucontrol)
   );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for the multicycle controller
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'b100011;
   logic [5:0] funct = 6'b000000;
   logic       zero = 1'b0;
   logic       memready = 1'b0;

   logic       memwrite, irwrite, regwrite, regdst, memtoreg, iord, alusrca, pcen;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;

   logic       n_memwrite, n_irwrite, n_regwrite, n_regdst, n_memtoreg, n_iord, n_alusrca, n_pcen;
   logic [1:0] n_alusrcb, n_pcsrc;
   logic [2:0] n_alucontrol;
   logic [3:0] n_state;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [3:0]  st;
      logic [11:0] ctl;
      logic [2:0]  alu;
      logic        alu_care;
   } exp_t;

   typedef struct packed {
      logic [5:0] op;
      logic [5:0] fn;
      logic [3:0] st;
      logic       mr;
      logic       z;
   } step_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
      .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst),
      .memtoreg(memtoreg), .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb),
      .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen), .state(state)
   );

   multicycle_ctrl #(.MEM_WAIT_EN(1'b0)) dut_nowait (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
      .memwrite(n_memwrite), .irwrite(n_irwrite), .regwrite(n_regwrite), .regdst(n_regdst),
      .memtoreg(n_memtoreg), .iord(n_iord), .alusrca(n_alusrca), .alusrcb(n_alusrcb),
      .pcsrc(n_pcsrc), .alucontrol(n_alucontrol), .pcen(n_pcen), .state(n_state)
   );

   // Observed control vector, same field order as the expected ctl
   function automatic logic [11:0] obs();
      return {memwrite, irwrite, regwrite, pcen, regdst, memtoreg, iord, alusrca, alusrcb, pcsrc};
   endfunction

   // Expected outputs for a state, from the per-state control table
   function automatic exp_t model(input int st, input logic mr, input logic z, input logic [5:0] fn);
      exp_t e;
      logic mw, iw, rw, pe, rd, mt, io, sa;
      logic [1:0] sb, ps;
      {mw, iw, rw, pe, rd, mt, io, sa} = 8'b0;
      sb = 2'b00;
      ps = 2'b00;
      e.alu = 3'b010;
      e.alu_care = 1'b1;
      case (st)
         0:  begin iw = mr; pe = mr; sb = 2'b01; end
         1:  sb = 2'b11;
         2:  begin sa = 1'b1; sb = 2'b10; end
         3:  io = 1'b1;
         4:  begin mt = 1'b1; rw = 1'b1; end
         5:  begin io = 1'b1; mw = 1'b1; end
         6:  begin
            sa = 1'b1;
            case (fn)
               6'b100000: e.alu = 3'b010;
               6'b100010: e.alu = 3'b110;
               6'b100100: e.alu = 3'b000;
               6'b100101: e.alu = 3'b001;
               6'b101010: e.alu = 3'b111;
               default:   e.alu_care = 1'b0;
            endcase
         end
         7:  begin rd = 1'b1; rw = 1'b1; end
         8:  begin sa = 1'b1; ps = 2'b01; pe = z; e.alu = 3'b110; end
         9:  begin sa = 1'b1; sb = 2'b10; end
         10: rw = 1'b1;
         11: begin ps = 2'b10; pe = 1'b1; end
         default: ;
      endcase
      e.st = st[3:0];
      e.ctl = {mw, iw, rw, pe, rd, mt, io, sa, sb, ps};
      return e;
   endfunction

   // Drive one cycle of stimulus just after the edge and queue its expectation
   task automatic drive(input logic rst, input logic [5:0] o, input logic [5:0] fn,
                        input logic mr, input logic z, input int st);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst;
      op = o;
      funct = fn;
      memready = mr;
      zero = z;
      e = model(st, mr, z, fn);
      if (rst) e.ctl[11:8] = 4'b0000;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      step_t seq[13];
      logic  rst[13];
      exp_t  e;
      seq = '{'{6'b100011, 6'd0, 4'd0, 1'b0, 1'b0}, '{6'b100011, 6'd0, 4'd0, 1'b1, 1'b0},
              '{6'b100011, 6'd0, 4'd0, 1'b1, 1'b0}, '{6'b100011, 6'd0, 4'd1, 1'b1, 1'b0},
              '{6'b100011, 6'd0, 4'd2, 1'b1, 1'b0}, '{6'b100011, 6'd0, 4'd3, 1'b0, 1'b0},
              '{6'b100011, 6'd0, 4'd3, 1'b0, 1'b0}, '{6'b100011, 6'd0, 4'd3, 1'b1, 1'b0},
              '{6'b100011, 6'd0, 4'd0, 1'b1, 1'b0}, '{6'b100011, 6'd0, 4'd0, 1'b1, 1'b0},
              '{6'b100011, 6'd0, 4'd0, 1'b1, 1'b0}, '{6'b100011, 6'd0, 4'd1, 1'b1, 1'b0},
              '{6'b100011, 6'd0, 4'd2, 1'b1, 1'b0}};
      rst = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 13; i++) begin
         drive(rst[i], seq[i].op, seq[i].fn, seq[i].mr, seq[i].z, int'(seq[i].st));
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (state !== e.st) begin
            errors++;
            $display("FAIL reset_state[%0d] got=%0d exp=%0d", i, state, e.st);
         end
         checks++;
         if (obs() !== e.ctl) begin
            errors++;
            $display("FAIL reset_ctl[%0d] got=%b exp=%b", i, obs(), e.ctl);
         end
      end
      // finish the interrupted-then-restarted lw so the next test starts in FETCH
      drive(1'b0, 6'b100011, 6'd0, 1'b1, 1'b0, 3);
      drive(1'b0, 6'b100011, 6'd0, 1'b1, 1'b0, 4);
      @(negedge clk);
      void'(exp_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st || obs() !== e.ctl) begin
         errors++;
         $display("FAIL reset_tail got=%0d/%b exp=%0d/%b", state, obs(), e.st, e.ctl);
      end
   endtask

   task automatic test_instr_mix();
      step_t seq[23];
      exp_t  e;
      seq = '{'{6'b100011, 6'd0, 4'd0, 1'b1, 1'b0}, '{6'b100011, 6'd0, 4'd1, 1'b1, 1'b0},
              '{6'b100011, 6'd0, 4'd2, 1'b1, 1'b0}, '{6'b100011, 6'd0, 4'd3, 1'b1, 1'b0},
              '{6'b100011, 6'd0, 4'd4, 1'b1, 1'b0},
              '{6'b000000, 6'b101010, 4'd0, 1'b1, 1'b0}, '{6'b000000, 6'b101010, 4'd1, 1'b1, 1'b0},
              '{6'b000000, 6'b101010, 4'd6, 1'b1, 1'b0}, '{6'b000000, 6'b101010, 4'd7, 1'b1, 1'b0},
              '{6'b000000, 6'b100010, 4'd0, 1'b1, 1'b0}, '{6'b000000, 6'b100010, 4'd1, 1'b1, 1'b0},
              '{6'b000000, 6'b100010, 4'd6, 1'b1, 1'b1}, '{6'b000000, 6'b100010, 4'd7, 1'b1, 1'b1},
              '{6'b001000, 6'd0, 4'd0, 1'b1, 1'b0}, '{6'b001000, 6'd0, 4'd1, 1'b1, 1'b0},
              '{6'b001000, 6'd0, 4'd9, 1'b1, 1'b0}, '{6'b001000, 6'd0, 4'd10, 1'b1, 1'b0},
              '{6'b000010, 6'd0, 4'd0, 1'b1, 1'b0}, '{6'b000010, 6'd0, 4'd1, 1'b1, 1'b0},
              '{6'b000010, 6'd0, 4'd11, 1'b1, 1'b0},
              '{6'b111111, 6'd0, 4'd0, 1'b1, 1'b0}, '{6'b111111, 6'd0, 4'd1, 1'b1, 1'b0},
              '{6'b111111, 6'd0, 4'd0, 1'b0, 1'b0}};
      for (int i = 0; i < 23; i++) begin
         drive(1'b0, seq[i].op, seq[i].fn, seq[i].mr, seq[i].z, int'(seq[i].st));
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (state !== e.st) begin
            errors++;
            $display("FAIL mix_state[%0d] got=%0d exp=%0d", i, state, e.st);
         end
         checks++;
         if (obs() !== e.ctl) begin
            errors++;
            $display("FAIL mix_ctl[%0d] got=%b exp=%b", i, obs(), e.ctl);
         end
         if (e.alu_care) begin
            checks++;
            if (alucontrol !== e.alu) begin
               errors++;
               $display("FAIL mix_alu[%0d] got=%b exp=%b", i, alucontrol, e.alu);
            end
         end
      end
   endtask

   task automatic test_sw_wait();
      step_t seq[7];
      exp_t  e;
      int    mw_run = 0;
      seq = '{'{6'b101011, 6'd0, 4'd0, 1'b1, 1'b0}, '{6'b101011, 6'd0, 4'd1, 1'b1, 1'b0},
              '{6'b101011, 6'd0, 4'd2, 1'b1, 1'b0}, '{6'b101011, 6'd0, 4'd5, 1'b0, 1'b0},
              '{6'b101011, 6'd0, 4'd5, 1'b0, 1'b0}, '{6'b101011, 6'd0, 4'd5, 1'b1, 1'b0},
              '{6'b101011, 6'd0, 4'd0, 1'b0, 1'b0}};
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, seq[i].op, seq[i].fn, seq[i].mr, seq[i].z, int'(seq[i].st));
         @(negedge clk);
         if (memwrite === 1'b1) mw_run++;
         e = exp_q.pop_front();
         checks++;
         if (state !== e.st) begin
            errors++;
            $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, state, e.st);
         end
         checks++;
         if (obs() !== e.ctl) begin
            errors++;
            $display("FAIL sw_ctl[%0d] got=%b exp=%b", i, obs(), e.ctl);
         end
      end
      checks++;
      if (mw_run !== 3) begin
         errors++;
         $display("FAIL sw_memwrite_cycles got=%0d exp=3", mw_run);
      end
   endtask

   task automatic test_branch();
      step_t seq[6];
      exp_t  e;
      seq = '{'{6'b000100, 6'd0, 4'd0, 1'b1, 1'b0}, '{6'b000100, 6'd0, 4'd1, 1'b1, 1'b1},
              '{6'b000100, 6'd0, 4'd8, 1'b1, 1'b1},
              '{6'b000100, 6'd0, 4'd0, 1'b1, 1'b1}, '{6'b000100, 6'd0, 4'd1, 1'b1, 1'b0},
              '{6'b000100, 6'd0, 4'd8, 1'b1, 1'b0}};
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, seq[i].op, seq[i].fn, seq[i].mr, seq[i].z, int'(seq[i].st));
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (state !== e.st) begin
            errors++;
            $display("FAIL beq_state[%0d] got=%0d exp=%0d", i, state, e.st);
         end
         checks++;
         if (obs() !== e.ctl) begin
            errors++;
            $display("FAIL beq_ctl[%0d] got=%b exp=%b", i, obs(), e.ctl);
         end
         checks++;
         if (alucontrol !== e.alu) begin
            errors++;
            $display("FAIL beq_alu[%0d] got=%b exp=%b", i, alucontrol, e.alu);
         end
      end
   endtask

   task automatic test_nowait();
      exp_t e;
      logic [3:0] n_exp_st[3];
      logic       n_exp_ir[3];
      n_exp_st = '{4'd0, 4'd0, 4'd1};
      n_exp_ir = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         drive((i == 0) ? 1'b1 : 1'b0, 6'b100011, 6'd0, 1'b0, 1'b0, 0);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (state !== e.st || obs() !== e.ctl) begin
            errors++;
            $display("FAIL nowait_main[%0d] got=%0d/%b exp=%0d/%b", i, state, obs(), e.st, e.ctl);
         end
         checks++;
         if (n_state !== n_exp_st[i]) begin
            errors++;
            $display("FAIL nowait_state[%0d] got=%0d exp=%0d", i, n_state, n_exp_st[i]);
         end
         checks++;
         if (n_irwrite !== n_exp_ir[i] || n_pcen !== n_exp_ir[i]) begin
            errors++;
            $display("FAIL nowait_irwrite[%0d] got=%b/%b exp=%b", i, n_irwrite, n_pcen, n_exp_ir[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_instr_mix();
      test_sw_wait();
      test_branch();
      test_nowait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
